// File: rtl/dmem_arbiter_pkg.sv
// Purpose : shared types and defaults for the dmem arbiter slice.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package dmem_arb_pkg;

    // Arbitration mode: core priority, or a one-cycle forced ext slot.
    typedef enum logic {
        ARB_CORE  = 1'b0,
        ARB_FORCE = 1'b1
    } arb_state_t;

    // Which requester drives the memory port this cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    localparam int WADDR_WIDTH_DEF = 30;
    localparam int DATA_WIDTH_DEF  = 32;
    localparam int STARVE_CNT_W    = 4;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Purpose : saturating wait counter for the external requester; flags the
//           increment that reaches LIMIT.
// Latency : hit_o is combinational from the current count and inc_i.
// Backpr. : none; clr_i dominates inc_i.
// Ports   : clk/reset (sync, active-high), clr_i, inc_i, hit_o.
module starve_counter
    import dmem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] cnt_q;
    logic [STARVE_CNT_W-1:0] cnt_d;
    logic [STARVE_CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LIMIT_V)) begin
            // Saturate at LIMIT; the forced slot clears it before it could wrap.
            cnt_d = cnt_inc;
        end
    end

    assign hit_o = inc_i && !clr_i && (cnt_inc == LIMIT_V);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Purpose : shares single-port dmem between core load/store and an external
//           requester; core has priority, ext gets a forced slot after
//           STARVE_LIMIT denied cycles.
// Latency : grant 0 cycles; ext read data 1 cycle after ext_gnt; core read
//           data combinational.
// Backpr. : core_stall when core loses; ext_req must be held until ext_gnt.
// Ports   : core_* (load/store path), ext_* (loader/debug port),
//           mem_* (to/from dmem), clk/reset (sync, active-high).
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int WADDR_WIDTH  = WADDR_WIDTH_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   core_req,
    input  logic                   core_we,
    input  logic [WADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]  core_wdata,
    output logic [DATA_WIDTH-1:0]  core_rdata,
    output logic                   core_stall,
    input  logic                   ext_req,
    input  logic                   ext_we,
    input  logic [WADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0]  ext_wdata,
    output logic                   ext_gnt,
    output logic                   ext_rvalid,
    output logic [DATA_WIDTH-1:0]  ext_rdata,
    output logic [WADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_w_en,
    output logic                   mem_read_en,
    input  logic [DATA_WIDTH-1:0]  mem_rdata
);

    arb_state_t            state_q;
    arb_state_t            state_d;
    owner_t                owner;
    logic                  starve_hit;
    logic                  ext_rvalid_q;
    logic                  ext_rvalid_d;
    logic [DATA_WIDTH-1:0] ext_rdata_q;
    logic [DATA_WIDTH-1:0] ext_rdata_d;

    // Owner selection. In ARB_FORCE a requesting ext wins; if ext dropped its
    // request the core still gets the port without a stall.
    always_comb begin
        owner = OWN_NONE;
        if (!reset) begin
            if ((state_q == ARB_FORCE) && ext_req) begin
                owner = OWN_EXT;
            end else if (core_req) begin
                owner = OWN_CORE;
            end else if (ext_req) begin
                owner = OWN_EXT;
            end
        end
    end

    assign ext_gnt    = (owner == OWN_EXT);
    assign core_stall = !reset && core_req && (owner != OWN_CORE);
    assign core_rdata = mem_rdata;

    // Memory port mux; idle port is driven to all-zero.
    always_comb begin
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_w_en    = 1'b0;
        mem_read_en = 1'b0;
        unique case (owner)
            OWN_CORE: begin
                mem_addr    = core_addr;
                mem_wdata   = core_wdata;
                mem_w_en    = core_we;
                mem_read_en = !core_we;
            end
            OWN_EXT: begin
                mem_addr    = ext_addr;
                mem_wdata   = ext_wdata;
                mem_w_en    = ext_we;
                mem_read_en = !ext_we;
            end
            default: ;
        endcase
    end

    // Withdrawing the request forfeits accumulated wait.
    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .clr_i (!ext_req || ext_gnt),
        .inc_i (ext_req && !ext_gnt),
        .hit_o (starve_hit)
    );

    // ARB_FORCE lasts exactly one cycle whatever ext does in it.
    always_comb begin
        state_d = ARB_CORE;
        if ((state_q == ARB_CORE) && starve_hit) begin
            state_d = ARB_FORCE;
        end
    end

    always_comb begin
        ext_rvalid_d = ext_gnt && !ext_we;
        ext_rdata_d  = ext_rdata_q;
        if (ext_gnt && !ext_we) begin
            ext_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_CORE;
            ext_rvalid_q <= 1'b0;
            ext_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            ext_rvalid_q <= ext_rvalid_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

    // A reset arriving the cycle after a read grant must suppress the pulse,
    // so the registered valid is masked while reset is high.
    assign ext_rvalid = ext_rvalid_q && !reset;
    assign ext_rdata  = ext_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port dmem.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we;
    logic [29:0] core_addr;
    logic [31:0] core_wdata, core_rdata;
    logic        core_stall;
    logic        ext_req, ext_we;
    logic [29:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        ext_gnt, ext_rvalid;
    logic [31:0] ext_rdata;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_w_en, mem_read_en;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // dmem: combinational read, write at the clock edge.
    assign mem_rdata = mem[mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_w_en) mem[mem_addr[7:0]] <= mem_wdata;
    end

    dmem_arbiter #(
        .DATA_WIDTH   (32),
        .WADDR_WIDTH  (30),
        .STARVE_LIMIT (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_rdata  (core_rdata),
        .core_stall  (core_stall),
        .ext_req     (ext_req),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_wdata   (ext_wdata),
        .ext_gnt     (ext_gnt),
        .ext_rvalid  (ext_rvalid),
        .ext_rdata   (ext_rdata),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_w_en    (mem_w_en),
        .mem_read_en (mem_read_en),
        .mem_rdata   (mem_rdata)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_core(input logic req, input logic we, input logic [29:0] addr, input logic [31:0] wd);
        core_req = req; core_we = we; core_addr = addr; core_wdata = wd;
    endtask

    task automatic drive_ext(input logic req, input logic we, input logic [29:0] addr, input logic [31:0] wd);
        ext_req = req; ext_we = we; ext_addr = addr; ext_wdata = wd;
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_port(input string tag);
        check_eq({tag, "_gnt"},   ext_gnt,     0);
        check_eq({tag, "_stall"}, core_stall,  0);
        check_eq({tag, "_wen"},   mem_w_en,    0);
        check_eq({tag, "_ren"},   mem_read_en, 0);
        check_eq({tag, "_addr"},  mem_addr,    0);
        check_eq({tag, "_wdata"}, mem_wdata,   0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;

        // Reset with both requesters active: port must be forced idle.
        reset = 1'b1;
        drive_core(1'b1, 1'b1, 30'h5, 32'hAAAA5555);
        drive_ext(1'b1, 1'b0, 30'h6, 32'h0);
        tick();
        @(negedge clk);
        check_zero_port("rst");
        check_eq("rst_rvalid", ext_rvalid, 0);
        check_eq("rst_rdata",  ext_rdata,  0);
        tick();

        // Idle.
        reset = 1'b0;
        drive_core(1'b0, 1'b0, 30'h0, 32'h0);
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        check_zero_port("idle");
        tick();

        // Core store then load.
        drive_core(1'b1, 1'b1, 30'h10, 32'hDEADBEEF);
        @(negedge clk);
        check_eq("core_st_stall", core_stall, 0);
        check_eq("core_st_wen",   mem_w_en,   1);
        check_eq("core_st_addr",  mem_addr,   32'h10);
        check_eq("core_st_wdata", mem_wdata,  32'hDEADBEEF);
        tick();
        drive_core(1'b1, 1'b0, 30'h10, 32'h0);
        @(negedge clk);
        check_eq("core_ld_stall", core_stall,  0);
        check_eq("core_ld_ren",   mem_read_en, 1);
        check_eq("core_ld_rdata", core_rdata,  32'hDEADBEEF);
        tick();

        // Ext write then read.
        drive_core(1'b0, 1'b0, 30'h0, 32'h0);
        drive_ext(1'b1, 1'b1, 30'h20, 32'h12345678);
        @(negedge clk);
        check_eq("ext_wr_gnt", ext_gnt,  1);
        check_eq("ext_wr_wen", mem_w_en, 1);
        tick();
        drive_ext(1'b1, 1'b0, 30'h20, 32'h0);
        @(negedge clk);
        check_eq("ext_wr_rvalid", ext_rvalid,  0);
        check_eq("ext_rd_gnt",    ext_gnt,     1);
        check_eq("ext_rd_ren",    mem_read_en, 1);
        tick();
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        check_eq("ext_rd_rvalid", ext_rvalid, 1);
        check_eq("ext_rd_rdata",  ext_rdata,  32'h12345678);
        tick();
        @(negedge clk);
        check_eq("ext_rvalid_pulse", ext_rvalid, 0);
        check_eq("ext_rdata_hold",   ext_rdata,  32'h12345678);
        tick();

        // Starvation: continuous core loads, ext read granted in cycle 4.
        drive_core(1'b1, 1'b0, 30'h10, 32'h0);
        drive_ext(1'b1, 1'b0, 30'h20, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("starve_gnt_c%0d", c),   ext_gnt,    (c == 4) ? 1 : 0);
            check_eq($sformatf("starve_stall_c%0d", c), core_stall, (c == 4) ? 1 : 0);
            if (c == 4) check_eq("starve_addr_c4", mem_addr, 32'h20);
            tick();
        end
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        check_eq("starve_resume_stall", core_stall, 0);
        check_eq("starve_resume_rdata", core_rdata, 32'hDEADBEEF);
        check_eq("starve_rvalid",       ext_rvalid, 1);
        check_eq("starve_rdata",        ext_rdata,  32'h12345678);
        tick();

        // Withdrawal: 3 denied cycles, drop one cycle, then a full fresh wait.
        drive_ext(1'b1, 1'b0, 30'h20, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("wd_pre_gnt_c%0d", c), ext_gnt, 0);
            tick();
        end
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        @(negedge clk);
        check_eq("wd_drop_gnt", ext_gnt, 0);
        tick();
        drive_ext(1'b1, 1'b0, 30'h20, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("wd_post_gnt_c%0d", c), ext_gnt, (c == 4) ? 1 : 0);
            tick();
        end
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        tick();

        // Reset at starve count 3, then a fresh 4-cycle wait.
        drive_ext(1'b1, 1'b0, 30'h20, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq($sformatf("rm_pre_gnt_c%0d", c), ext_gnt, 0);
            tick();
        end
        reset = 1'b1;
        @(negedge clk);
        check_zero_port("rm_rst");
        tick();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq($sformatf("rm_post_gnt_c%0d", c),   ext_gnt,    (c == 4) ? 1 : 0);
            check_eq($sformatf("rm_post_stall_c%0d", c), core_stall, (c == 4) ? 1 : 0);
            tick();
        end
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        drive_core(1'b0, 1'b0, 30'h0, 32'h0);
        tick();

        // Reset in the cycle after an ext read grant.
        drive_ext(1'b1, 1'b0, 30'h20, 32'h0);
        @(negedge clk);
        check_eq("rg_gnt", ext_gnt, 1);
        tick();
        drive_ext(1'b0, 1'b0, 30'h0, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("rg_rst_rvalid", ext_rvalid,  0);
        check_eq("rg_rst_wen",    mem_w_en,    0);
        check_eq("rg_rst_ren",    mem_read_en, 0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rg_post_rvalid", ext_rvalid, 0);
        check_eq("rg_post_rdata",  ext_rdata,  0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory (`dmem`) between the core's load/store path and a second external requester, such as a program loader or debug port. Core accesses win by default. A starvation counter guarantees the external port a slot after a bounded wait, and the core's PC/pipeline is stalled for that cycle. The block sits between the core datapath (ALU address, rs2 store data, writeback mux) and the `dmem` instance.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: data width.
- `WADDR_WIDTH`, default 30: word-address width (byte address bits [31:2]).
- `STARVE_LIMIT`, default 4: maximum number of consecutive cycles the external port may be denied; legal range 1..15.

Ports (one clock `clk`; `reset` is synchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `core_req` in 1: core load/store this cycle.
- `core_we` in 1: 1 = store, 0 = load.
- `core_addr` in WADDR_WIDTH: core word address.
- `core_wdata` in DATA_WIDTH: core store data.
- `core_rdata` out DATA_WIDTH: load data, combinational from `mem_rdata`.
- `core_stall` out 1: core access not performed this cycle; deasserts PCen.
- `ext_req` in 1: external access request; held until granted.
- `ext_we` in 1: external write flag.
- `ext_addr` in WADDR_WIDTH: external word address.
- `ext_wdata` in DATA_WIDTH: external write data.
- `ext_gnt` out 1: external access performed this cycle.
- `ext_rvalid` out 1: registered; external read data valid.
- `ext_rdata` out DATA_WIDTH: registered external read data.
- `mem_addr` out WADDR_WIDTH: to `dmem`.
- `mem_wdata` out DATA_WIDTH: to `dmem`.
- `mem_w_en` out 1: to `dmem`.
- `mem_read_en` out 1: to `dmem`.
- `mem_rdata` in DATA_WIDTH: from `dmem`; combinational read; write occurs at the clock edge.

## Operation
- Owner selection each cycle is combinational from inputs and registered state. Two states:
  - `ARB_CORE` (default): core wins if `core_req`; otherwise ext wins if `ext_req`.
  - `ARB_FORCE`: ext wins if `ext_req`; core is stalled.
- Starvation counter `starve_cnt` (4 bits):
  - Increments each cycle `ext_req && !ext_gnt`.
  - Clears on `ext_gnt`.
  - Clears on `!ext_req`; ext withdrawing its request is legal but forfeits its accumulated wait.
- Transitions:
  - `ARB_CORE` -> `ARB_FORCE` when the increment makes `starve_cnt == STARVE_LIMIT`.
  - `ARB_FORCE` -> `ARB_CORE` after exactly one cycle, regardless of whether ext is granted.
- Winner drives `mem_addr`/`mem_wdata`/`mem_w_en = we`/`mem_read_en = !we`.
- With no winner: `mem_w_en = mem_read_en = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- `core_stall = core_req && !core_win`.
- `ext_gnt = ext_win`.
- External read (`ext_gnt && !ext_we`): `ext_rdata <= mem_rdata` and `ext_rvalid <= 1` at the next edge.
- `ext_rvalid` is a one-cycle pulse; `ext_rdata` holds its value until the next external read.
- External write: `ext_rvalid` stays 0.
- Core read data passes through unregistered; it is valid in the cycle `core_req && !core_stall`.

## Timing
- Reset (synchronous): state = `ARB_CORE`, `starve_cnt = 0`, `ext_rvalid = 0`, `ext_rdata = 0`.
- While `reset` is high, all combinational outputs are forced low: `ext_gnt = 0`, `core_stall = 0`, `mem_w_en = 0`, `mem_read_en = 0`, `mem_addr = 0`, `mem_wdata = 0`.
- Reset mid-wait discards pending ext wait time; ext must still hold `ext_req`.
- Reset in the cycle after an ext read grant: `ext_rvalid` stays 0 (reset wins).
- Grant latency: 0 cycles for the winner.
- External read data latency: 1 cycle after `ext_gnt`.
- Worst-case ext wait with continuous `core_req`: `STARVE_LIMIT` denied cycles, then granted in cycle `STARVE_LIMIT + 1`.
- Simultaneous `core_req` and `ext_req` in `ARB_FORCE`: ext wins, core stalls one cycle.
- Same-address core load and ext write in the same cycle: impossible, since only one access per cycle.
- Across a grant boundary, memory write-then-read ordering is preserved by `dmem`.
- `ARB_FORCE` with `ext_req = 0` (request dropped during the transition cycle): core wins if requesting, no stall. The state returns to `ARB_CORE` regardless.
- `starve_cnt` never exceeds `STARVE_LIMIT`; no wrap-around.

## Structure
- Package `dmem_arb_pkg` holds:
  - `arb_state_t` enum {`ARB_CORE`, `ARB_FORCE`}.
  - `owner_t` enum {`OWN_NONE`, `OWN_CORE`, `OWN_EXT`}.
  - `WADDR_WIDTH_DEF` and `DATA_WIDTH_DEF` constants.
- One sub-module: `starve_counter`, a saturating counter with clear/inc inputs and a limit-hit flag.
- The owner mux and the response register stay in `dmem_arbiter`.

## Test plan
1. **Core only, no ext.** Stimulus: core stores 0xDEADBEEF at word 0x10, then loads word 0x10. Required: `core_stall = 0` in both cycles; `core_rdata = 0xDEADBEEF` in the load cycle.
2. **Ext only.** Stimulus: ext writes 0x12345678 at word 0x20, then reads word 0x20. Required: `ext_gnt = 1` in both cycles; `ext_rvalid` pulses the cycle after the read with `ext_rdata = 0x12345678`.
3. **Starvation (`STARVE_LIMIT = 4`).** Stimulus: `core_req` held high continuously; `ext_req` (read) asserted at cycle 0. Required: `ext_gnt` = 0 in cycles 0-3 and = 1 in cycle 4, where `core_stall = 1`; core resumes in cycle 5.
4. **Request withdrawal.** Stimulus: ext waits 3 cycles under core traffic, drops `ext_req` for 1 cycle, then reasserts. Required: the counter restarts and the next grant arrives 4 cycles after reassertion.
5. **Reset mid-operation.** Stimulus: assert `reset` at the starve count of 3, and separately in the cycle after an ext read grant. Required: `ext_rvalid = 0`, all enables 0; after release, a fresh 4-cycle wait before the forced grant.
6. **Idle.** Stimulus: no requests. Required: `mem_w_en = mem_read_en = 0`, `core_stall = 0`, `ext_gnt = 0`.
